ttc_cmd_scheduler: RTL and testbench

TTC_CMD_SCHEDULER -- requirements
Module: ttc_cmd_scheduler

---
 rtl/ttc_sched_pkg.sv | 35 +++
 rtl/ttc_orbit_counter.sv | 38 +++
 rtl/ttc_cmd_scheduler.sv | 170 +++++++++++++++++
 tb/tb_ttc_cmd_scheduler.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ttc_sched_pkg.sv
// ttc_sched_pkg -- shared types and defaults for the TTC command scheduler.
//   cmd_e      : command selected for the current slot
//   state_e    : scheduler slot FSM states
//   cmd_onehot : maps a command to the {mreset, ecr, bcr, trigger} enable vector
package ttc_sched_pkg;

    typedef enum logic [2:0] {
        CMD_NONE   = 3'd0,
        CMD_MRESET = 3'd1,
        CMD_BCR    = 3'd2,
        CMD_ECR    = 3'd3,
        CMD_TRIG   = 3'd4
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    localparam int          SLOT_LEN_DEF  = 6;
    localparam logic [11:0] ORBIT_LEN_DEF = 12'd3563;

    // Bit order matches the enable outputs: [3]=mreset [2]=ecr [1]=bcr [0]=trigger.
    function automatic logic [3:0] cmd_onehot(input cmd_e cmd);
        case (cmd)
            CMD_MRESET: return 4'b1000;
            CMD_ECR:    return 4'b0100;
            CMD_BCR:    return 4'b0010;
            CMD_TRIG:   return 4'b0001;
            default:    return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/ttc_orbit_counter.sv
// ttc_orbit_counter -- free-running orbit position used for periodic BCR.
//   clk_40, rst_40_n : clock, asynchronous active-low reset
//   bcr_auto_en      : count enable; counter is held at 0 when low
//   bcr_period       : last count value of the orbit (orbit length - 1)
//   req_bcr          : explicit BCR request; realigns the orbit to 0
//   wrap             : 1-cycle pulse in the cycle the counter sits at bcr_period
//   count            : current orbit position
module ttc_orbit_counter
    import ttc_sched_pkg::*;
(
    input  logic        clk_40,
    input  logic        rst_40_n,
    input  logic        bcr_auto_en,
    input  logic [11:0] bcr_period,
    input  logic        req_bcr,
    output logic        wrap,
    output logic [11:0] count
);

    // Combinational so the scheduler marks BCR pending on the same edge the
    // counter returns to 0. With bcr_period=0 this stays high permanently.
    assign wrap = bcr_auto_en && (count == bcr_period);

    // If bcr_period is lowered below the current count, the counter runs on
    // to 4095 and rolls over naturally before re-locking.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk_40 or negedge rst_40_n) begin
        if (!rst_40_n) begin
            count <= '0;
        end else if (!bcr_auto_en || req_bcr || wrap) begin
            count <= '0;
        end else begin
            count <= count + 12'd1;
        end
    end

endmodule

// File: rtl/ttc_cmd_scheduler.sv
// ttc_cmd_scheduler -- queues TTC command requests and issues them to the TTC
// generator one per slot, in priority order mreset > bcr > ecr > trigger.
//   clk_40, rst_40_n       : clock, asynchronous active-low reset
//   sched_en               : allows new slots to start
//   req_*                  : single-cycle request pulses
//   bcr_auto_en/bcr_period : periodic BCR generation
//   ovf_clear              : clears trig_overflow
//   start_single           : 1-cycle start pulse to the generator
//   *_en                   : command select, held for the whole slot
//   sched_busy             : slot in progress
//   trig_pending           : queued triggers (saturating)
//   trig_overflow          : sticky, a trigger was dropped
module ttc_cmd_scheduler
    import ttc_sched_pkg::*;
#(
    parameter int SLOT_LEN   = SLOT_LEN_DEF,
    parameter int TRIG_CNT_W = 4
) (
    input  logic                  clk_40,
    input  logic                  rst_40_n,
    input  logic                  sched_en,
    input  logic                  req_trigger,
    input  logic                  req_bcr,
    input  logic                  req_ecr,
    input  logic                  req_mreset,
    input  logic                  bcr_auto_en,
    input  logic [11:0]           bcr_period,
    input  logic                  ovf_clear,
    output logic                  start_single,
    output logic                  trigger_en,
    output logic                  bc_reset_en,
    output logic                  event_reset_en,
    output logic                  master_reset_en,
    output logic                  sched_busy,
    output logic [TRIG_CNT_W-1:0] trig_pending,
    output logic                  trig_overflow
);

    localparam int                HOLD_W    = $clog2(SLOT_LEN);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SLOT_LEN - 2);

    state_e                  state, state_n;
    logic [HOLD_W-1:0]       hold_cnt, hold_cnt_n;
    logic [3:0]              en_q, en_n;
    logic                    start_n;
    logic                    mreset_pend, bcr_pend, ecr_pend;
    logic                    any_pend, deq, deq_m, deq_b, deq_e, deq_t;
    logic                    trig_full, trig_drop;
    logic [TRIG_CNT_W-1:0]   trig_n;
    cmd_e                    sel;
    logic                    orbit_wrap;
    logic [11:0]             orbit_count_unused; // debug tap only

    ttc_orbit_counter u_orbit (
        .clk_40      (clk_40),
        .rst_40_n    (rst_40_n),
        .bcr_auto_en (bcr_auto_en),
        .bcr_period  (bcr_period),
        .req_bcr     (req_bcr),
        .wrap        (orbit_wrap),
        .count       (orbit_count_unused)
    );

    // ---------------- dequeue selection ----------------
    assign any_pend = mreset_pend || bcr_pend || ecr_pend || (trig_pending != '0);

    always_comb begin
        if (mreset_pend)              sel = CMD_MRESET;
        else if (bcr_pend)            sel = CMD_BCR;
        else if (ecr_pend)            sel = CMD_ECR;
        else if (trig_pending != '0)  sel = CMD_TRIG;
        else                          sel = CMD_NONE;
    end

    assign deq   = (state == ST_IDLE) && sched_en && any_pend;
    assign deq_m = deq && (sel == CMD_MRESET);
    assign deq_b = deq && (sel == CMD_BCR);
    assign deq_e = deq && (sel == CMD_ECR);
    assign deq_t = deq && (sel == CMD_TRIG);

    // ---------------- trigger counter ----------------
    assign trig_full = &trig_pending;
    // A trigger coinciding with its own dequeue nets zero and is never dropped;
    // one coinciding with an mreset dequeue survives the flush.
    assign trig_drop = req_trigger && trig_full && !deq_t && !deq_m;

    always_comb begin
        trig_n = trig_pending;
        if (deq_m)                        trig_n = TRIG_CNT_W'(req_trigger);
        else if (req_trigger && !deq_t)   trig_n = trig_full ? trig_pending
                                                             : trig_pending + TRIG_CNT_W'(1);
        else if (!req_trigger && deq_t)   trig_n = trig_pending - TRIG_CNT_W'(1);
    end

    // Request set takes priority over dequeue clear on every flag.
    always_ff @(posedge clk_40 or negedge rst_40_n) begin
        if (!rst_40_n) begin
            mreset_pend   <= 1'b0;
            bcr_pend      <= 1'b0;
            ecr_pend      <= 1'b0;
            trig_pending  <= '0;
            trig_overflow <= 1'b0;
        end else begin
            mreset_pend   <= req_mreset | (mreset_pend & ~deq_m);
            bcr_pend      <= req_bcr | orbit_wrap | (bcr_pend & ~deq_b);
            ecr_pend      <= req_ecr | (ecr_pend & ~(deq_e | deq_m));
            trig_pending  <= trig_n;
            trig_overflow <= trig_drop | (trig_overflow & ~ovf_clear);
        end
    end

    // ---------------- slot FSM ----------------
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_n    = state;
        hold_cnt_n = hold_cnt;
        en_n       = en_q;
        start_n    = 1'b0;
        case (state)
            ST_IDLE: begin
                en_n = '0;
                if (deq) begin
                    state_n = ST_ISSUE;
                    start_n = 1'b1;
                    en_n    = cmd_onehot(sel);
                end
            end
            ST_ISSUE: begin
                state_n    = ST_HOLD;
                hold_cnt_n = '0;
            end
            ST_HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_n = ST_IDLE;
                    en_n    = '0;
                end else begin
                    hold_cnt_n = hold_cnt + HOLD_W'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
                en_n    = '0;
            end
        endcase
    end

    // Outputs are registered from next-state values so they change with state.
    always_ff @(posedge clk_40 or negedge rst_40_n) begin
        if (!rst_40_n) begin
            state        <= ST_IDLE;
            hold_cnt     <= '0;
            en_q         <= '0;
            start_single <= 1'b0;
            sched_busy   <= 1'b0;
        end else begin
            state        <= state_n;
            hold_cnt     <= hold_cnt_n;
            en_q         <= en_n;
            start_single <= start_n;
            sched_busy   <= (state_n != ST_IDLE);
        end
    end

    assign master_reset_en = en_q[3];
    assign event_reset_en  = en_q[2];
    assign bc_reset_en     = en_q[1];
    assign trigger_en      = en_q[0];

endmodule

// File: tb/tb_ttc_cmd_scheduler.sv
`timescale 1ns/1ps
module tb_ttc_cmd_scheduler;

    logic        clk_40 = 1'b0;
    logic        rst_40_n;
    logic        sched_en, req_trigger, req_bcr, req_ecr, req_mreset;
    logic        bcr_auto_en, ovf_clear;
    logic [11:0] bcr_period;
    logic        start_single, trigger_en, bc_reset_en, event_reset_en, master_reset_en;
    logic        sched_busy, trig_overflow;
    logic [3:0]  trig_pending;

    int vectors     = 0;
    int miscompares = 0;

    ttc_cmd_scheduler #(.SLOT_LEN(6), .TRIG_CNT_W(4)) dut (
        .clk_40          (clk_40),
        .rst_40_n        (rst_40_n),
        .sched_en        (sched_en),
        .req_trigger     (req_trigger),
        .req_bcr         (req_bcr),
        .req_ecr         (req_ecr),
        .req_mreset      (req_mreset),
        .bcr_auto_en     (bcr_auto_en),
        .bcr_period      (bcr_period),
        .ovf_clear       (ovf_clear),
        .start_single    (start_single),
        .trigger_en      (trigger_en),
        .bc_reset_en     (bc_reset_en),
        .event_reset_en  (event_reset_en),
        .master_reset_en (master_reset_en),
        .sched_busy      (sched_busy),
        .trig_pending    (trig_pending),
        .trig_overflow   (trig_overflow)
    );

    always #5 clk_40 = ~clk_40;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // {mreset, ecr, bcr, trigger}
    function automatic logic [3:0] enables();
        return {master_reset_en, event_reset_en, bc_reset_en, trigger_en};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_40);
        #1;
    endtask

    // Ticks until start_single is seen or max ticks elapse; n = ticks taken.
    task automatic wait_start(input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!start_single && n < max);
    endtask

    initial begin
        int n, last, pulses;

        rst_40_n = 1'b0;  sched_en = 1'b1;
        req_trigger = 1'b0; req_bcr = 1'b0; req_ecr = 1'b0; req_mreset = 1'b0;
        bcr_auto_en = 1'b0; bcr_period = 12'd99; ovf_clear = 1'b0;

        // ---- reset state ----
        #12;
        chk("rst_start",   start_single, 1'b0);
        chk("rst_en",      enables(), 4'b0000);
        chk("rst_busy",    sched_busy, 1'b0);
        chk("rst_pending", trig_pending, 4'd0);
        chk("rst_ovf",     trig_overflow, 1'b0);
        @(negedge clk_40) rst_40_n = 1'b1;
        tick(); tick();

        // ---- single trigger: 2-clock latency, 6-cycle enable window ----
        req_trigger = 1'b1;
        tick();
        req_trigger = 1'b0;
        chk("single_pend1", trig_pending, 4'd1);
        chk("single_nostart", start_single, 1'b0);
        tick();
        chk("single_start", start_single, 1'b1);
        chk("single_en",    enables(), 4'b0001);
        chk("single_busy",  sched_busy, 1'b1);
        chk("single_pend0", trig_pending, 4'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("single_hold_start", start_single, 1'b0);
            chk("single_hold_en",    enables(), 4'b0001);
        end
        tick();
        chk("single_end_en",   enables(), 4'b0000);
        chk("single_end_busy", sched_busy, 1'b0);

        // ---- simultaneous requests: mreset, then bcr; ecr and trigger flushed ----
        req_trigger = 1'b1; req_bcr = 1'b1; req_ecr = 1'b1; req_mreset = 1'b1;
        tick();
        req_trigger = 1'b0; req_bcr = 1'b0; req_ecr = 1'b0; req_mreset = 1'b0;
        tick();
        chk("simul_mr_start", start_single, 1'b1);
        chk("simul_mr_en",    enables(), 4'b1000);
        chk("simul_flush",    trig_pending, 4'd0);
        wait_start(20, n);
        chk("simul_bcr_gap", n, 7);
        chk("simul_bcr_en",  enables(), 4'b0010);
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (start_single) pulses++;
        end
        chk("simul_no_more", pulses, 0);

        // ---- trigger saturation and overflow ----
        sched_en = 1'b0;
        req_trigger = 1'b1;
        repeat (20) tick();
        req_trigger = 1'b0;
        chk("sat_pending", trig_pending, 4'd15);
        chk("sat_ovf",     trig_overflow, 1'b1);
        ovf_clear = 1'b1; sched_en = 1'b1;
        tick();
        ovf_clear = 1'b0;
        chk("sat_ovf_clr",  trig_overflow, 1'b0);
        chk("sat_start",    start_single, 1'b1);
        chk("sat_pend14",   trig_pending, 4'd14);
        last = 0; pulses = 1;
        for (int i = 1; i <= 110; i++) begin
            tick();
            if (start_single) begin
                chk("sat_gap", i - last, 7);
                last = i;
                pulses++;
            end
        end
        chk("sat_pulses",  pulses, 15);
        chk("sat_drained", trig_pending, 4'd0);

        // ---- periodic BCR and realignment ----
        bcr_period = 12'd99; bcr_auto_en = 1'b1;
        wait_start(130, n);
        chk("auto_first",  start_single, 1'b1);
        chk("auto_first_en", enables(), 4'b0010);
        wait_start(130, n);
        chk("auto_period", n, 100);
        repeat (37) tick();
        req_bcr = 1'b1;
        tick();
        req_bcr = 1'b0;
        wait_start(10, n);
        chk("realign_latency", n, 1);
        chk("realign_en",      enables(), 4'b0010);
        wait_start(130, n);
        chk("realign_period", n, 100);
        bcr_auto_en = 1'b0;
        repeat (10) tick();

        // ---- reset mid-slot ----
        req_trigger = 1'b1;
        tick();
        req_trigger = 1'b0;
        tick();
        chk("rmid_start", start_single, 1'b1);
        req_ecr = 1'b1;
        tick();
        req_ecr = 1'b0;
        tick(); tick();
        #2 rst_40_n = 1'b0;
        #1;
        chk("rmid_start0", start_single, 1'b0);
        chk("rmid_en0",    enables(), 4'b0000);
        chk("rmid_busy0",  sched_busy, 1'b0);
        @(negedge clk_40) rst_40_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (start_single) pulses++;
        end
        chk("rmid_quiet", pulses, 0);

        // ---- trigger arriving on its own dequeue edge ----
        req_trigger = 1'b1;
        tick();
        tick();
        req_trigger = 1'b0;
        chk("deqreq_start",  start_single, 1'b1);
        chk("deqreq_pend",   trig_pending, 4'd1);
        wait_start(20, n);
        chk("deqreq_gap",    n, 7);
        chk("deqreq_en",     enables(), 4'b0001);
        chk("deqreq_pend0",  trig_pending, 4'd0);
        repeat (8) tick();

        // ---- sched_en dropped mid-slot: slot completes, queue held ----
        req_trigger = 1'b1;
        tick(); tick();
        req_trigger = 1'b0;
        chk("pause_start", start_single, 1'b1);
        sched_en = 1'b0;
        repeat (5) tick();
        chk("pause_hold_en", enables(), 4'b0001);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (start_single) pulses++;
        end
        chk("pause_quiet", pulses, 0);
        chk("pause_pend",  trig_pending, 4'd1);
        sched_en = 1'b1;
        wait_start(5, n);
        chk("resume_latency", n, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
